// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage owning the PC and the I-cache request interface.
// Ports:
//   clk, rst (async, active-low)       clock and reset
//   stall                              hazard-unit stall, holds PC and fetch state
//   redirect, redirect_pc              taken branch/jump resolved in ID and its target
//   imem_req, imem_addr                fetch request and address (address equals pc_q)
//   imem_valid, imem_rdata             fetch response, same cycle on a hit or later on a miss
//   IF_pc, IF_instr                    pc_q + 2 and fetched instruction (or NOP bubble) to IF/ID
//   fetch_bubble                       IF_instr is a bubble rather than a fetched instruction
//   halted                             HLT has been fetched and fetch is stopped
module if_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'h4000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] IF_pc,
    output logic [15:0] IF_instr,
    output logic        fetch_bubble,
    output logic        halted
);
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN, S_HALT} state_t;
    state_t      state_q;
    logic [15:0] pc_q, redir_q;
    logic        fetching, good;
    assign fetching     = state_q == S_RUN || state_q == S_WAIT;
    // Gate with rst so a response arriving during reset never leaks into IF/ID.
    assign good         = rst & imem_valid & fetching;
    assign imem_req     = state_q != S_HALT;
    assign imem_addr    = pc_q;
    assign IF_pc        = pc_q + 16'd2;
    assign IF_instr     = good ? imem_rdata : NOP_INSTR;
    assign fetch_bubble = ~good;
    assign halted       = state_q == S_HALT;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            redir_q <= 16'h0000;
            state_q <= S_RUN;
        end else begin
            case (state_q)
                S_RUN, S_WAIT: begin
                    if (redirect && imem_valid) begin
                        pc_q    <= redirect_pc;
                        state_q <= S_RUN;
                    end else if (redirect) begin
                        // The outstanding miss must complete before the address may change.
                        redir_q <= redirect_pc;
                        state_q <= S_DRAIN;
                    end else if (stall) begin
                        if (state_q == S_RUN && !imem_valid) state_q <= S_WAIT;
                    end else if (!imem_valid) begin
                        state_q <= S_WAIT;
                    end else if (imem_rdata[15:12] == HLT_OPCODE) begin
                        state_q <= S_HALT;
                    end else begin
                        pc_q    <= pc_q + 16'd2;
                        state_q <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    if (redirect) redir_q <= redirect_pc;
                    if (imem_valid) begin
                        pc_q    <= redirect ? redirect_pc : redir_q;
                        state_q <= S_RUN;
                    end
                end
                S_HALT: begin
                    // Redirect means the HLT sat on a mispredicted path.
                    if (redirect) begin
                        pc_q    <= redirect_pc;
                        state_q <= S_RUN;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized self-checking bench for if_stage against a behavioural fetch model.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] IF_pc;
    logic [15:0] IF_instr;
    logic        fetch_bubble;
    logic        halted;
    int n_chk = 0;
    int n_fail = 0;
    // Model: where fetch points, whether it is stopped on HLT, and whether a
    // miss must finish (and be thrown away) before jumping to a pending target.
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_tgt = 16'h0000;
    bit          m_halt = 1'b0;
    bit          m_drain = 1'b0;
    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .IF_pc(IF_pc), .IF_instr(IF_instr), .fetch_bubble(fetch_bubble), .halted(halted)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_pc = 16'h0000;
        m_tgt = 16'h0000;
        m_halt = 1'b0;
        m_drain = 1'b0;
    endtask
    // One clock: apply inputs, compare combinational outputs with the model, advance both.
    task automatic step(input bit st, input bit rd, input logic [15:0] rpc, input bit v, input logic [15:0] d);
        bit good;
        stall = st;
        redirect = rd;
        redirect_pc = rpc;
        imem_valid = v;
        imem_rdata = d;
        #1;
        good = v && !m_halt && !m_drain;
        check("req", {15'd0, imem_req}, {15'd0, !m_halt});
        check("addr", imem_addr, m_pc);
        check("if_pc", IF_pc, m_pc + 16'd2);
        check("instr", IF_instr, good ? d : 16'h4000);
        check("bubble", {15'd0, fetch_bubble}, {15'd0, !good});
        check("halted", {15'd0, halted}, {15'd0, m_halt});
        if (m_halt) begin
            if (rd) begin
                m_pc = rpc;
                m_halt = 1'b0;
            end
        end else if (m_drain) begin
            if (rd) m_tgt = rpc;
            if (v) begin
                m_pc = m_tgt;
                m_drain = 1'b0;
            end
        end else if (rd) begin
            if (v) m_pc = rpc;
            else begin
                m_tgt = rpc;
                m_drain = 1'b1;
            end
        end else if (!st && v) begin
            if (d[15:12] == 4'hF) m_halt = 1'b1;
            else m_pc = m_pc + 16'd2;
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [15:0] r;
        repeat (2) @(posedge clk);
        #1;
        imem_valid = 1'b1;
        imem_rdata = 16'h1234;
        #1;
        check("rst_req", {15'd0, imem_req}, 16'd1);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_if_pc", IF_pc, 16'h0002);
        check("rst_instr", IF_instr, 16'h4000);
        check("rst_bubble", {15'd0, fetch_bubble}, 16'd1);
        check("rst_halted", {15'd0, halted}, 16'd0);
        rst = 1'b1;
        model_reset();
        // Hit streaming, then a 3-cycle miss at 4.
        step(0, 0, 0, 1, 16'h1111);
        step(0, 0, 0, 1, 16'h2222);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'h3333);
        step(0, 0, 0, 1, 16'h3333);
        check("after_miss_addr", imem_addr, 16'h0006);
        // Redirect during miss at 8, then a second redirect while draining.
        step(0, 0, 0, 1, 16'h4444);
        step(0, 1, 16'h0040, 0, 16'h5555);
        step(0, 0, 0, 0, 16'h5555);
        step(0, 1, 16'h0080, 0, 16'h5555);
        step(1, 0, 0, 1, 16'h5555);
        check("drain_target", imem_addr, 16'h0080);
        // Stall with hits at 0x10, then redirect overriding stall.
        step(0, 1, 16'h0010, 1, 16'h0000);
        step(1, 0, 0, 1, 16'h6666);
        step(1, 0, 0, 1, 16'h6666);
        check("stall_hold", imem_addr, 16'h0010);
        step(1, 1, 16'h0020, 1, 16'h6666);
        check("stall_redirect", imem_addr, 16'h0020);
        // HLT at 0x0C, then redirect out of HALT.
        step(0, 1, 16'h000C, 1, 16'h0000);
        step(0, 0, 0, 1, 16'hF000);
        step(0, 0, 0, 1, 16'h7777);
        step(0, 0, 0, 0, 16'h7777);
        step(0, 1, 16'h0030, 0, 16'h0000);
        check("resume_addr", imem_addr, 16'h0030);
        // PC wrap.
        step(0, 1, 16'hFFFE, 1, 16'h0000);
        step(0, 0, 0, 1, 16'h1234);
        check("wrap_addr", imem_addr, 16'h0000);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = 16'($urandom);
            step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, r & 16'hFFFE,
                 $urandom_range(0, 2) != 0, 16'($urandom));
        end
        // Asynchronous reset in the middle of a miss at 0x22.
        step(0, 1, 16'h0022, 1, 16'h0000);
        step(0, 0, 0, 0, 16'h0000);
        imem_valid = 1'b1;
        imem_rdata = 16'h2468;
        #1;
        rst = 1'b0;
        #1;
        check("arst_addr", imem_addr, 16'h0000);
        check("arst_instr", IF_instr, 16'h4000);
        check("arst_bubble", {15'd0, fetch_bubble}, 16'd1);
        check("arst_req", {15'd0, imem_req}, 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 16'h1000 + 16'(i));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit five-stage pipeline. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC register and drives the instruction-memory (I-cache) request interface, which may take multiple cycles.
- Produces IF_pc (PC+2) and IF_instr for IF/ID, or a NOP bubble (16'h4000) when no valid instruction is available.
- Handles branch redirect from ID, a pipeline stall from the hazard unit, and HLT detection.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h4000, bubble instruction driven when fetch has no valid instruction.
- HLT_OPCODE, 4'hF, value of instr[15:12] that identifies HLT.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall  input  1  hazard-unit stall; hold PC and state, same meaning as the IF/ID stall.
- redirect  input  1  taken branch/jump resolved in ID.
- redirect_pc  input  16  target PC for redirect.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  16  fetch address; equals pc_q.
- imem_valid  input  1  imem_rdata valid for current imem_addr; may arrive the same cycle (hit) or later (miss).
- imem_rdata  input  16  fetched instruction.
- IF_pc  output  16  pc_q + 2, to IF/ID.
- IF_instr  output  16  fetched instruction or NOP_INSTR.
- fetch_bubble  output  1  high when IF_instr is a bubble rather than a fetched instruction.
- halted  output  1  high in HALT state.

Behaviour:
- States: RUN, WAIT (miss outstanding), DRAIN (miss outstanding, result to be discarded), HALT. Encoding is free.
- Reset (rst low, async): pc_q=RESET_PC, state=RUN, redir_q=0. Outputs during reset: imem_req=1, imem_addr=RESET_PC, IF_pc=RESET_PC+2, IF_instr=NOP_INSTR, fetch_bubble=1, halted=0.
- Memory rule: once imem_req is high with an address, that address stays stable until imem_valid. In WAIT and DRAIN, pc_q never changes.
- imem_req=1 in RUN, WAIT and DRAIN; 0 in HALT.
- Comb outputs:
  - good = imem_valid and state in {RUN, WAIT}.
  - IF_instr = good ? imem_rdata : NOP_INSTR.
  - fetch_bubble = ~good.
  - IF_pc = pc_q + 2, wrapping mod 2^16 (16'hFFFE + 2 = 16'h0000).
  - halted = (state==HALT).
- RUN / WAIT, highest priority first:
  - redirect and imem_valid: pc_q<=redirect_pc; state<=RUN. Redirect overrides stall.
  - redirect and not imem_valid: redir_q<=redirect_pc; state<=DRAIN.
  - stall: hold pc_q and state. If in RUN with imem_valid=0, go to WAIT.
  - not imem_valid: state<=WAIT.
  - imem_valid and imem_rdata[15:12]==HLT_OPCODE: HLT is delivered this cycle (fetch_bubble=0); state<=HALT; pc_q holds the HLT address.
  - imem_valid otherwise: pc_q<=pc_q+2; state<=RUN.
- Stall with valid data: IF_instr is still driven. IF/ID holds its own contents, and the same address is re-requested next cycle.
- DRAIN:
  - IF_instr=NOP_INSTR.
  - A new redirect overwrites redir_q.
  - On imem_valid, discard the data; pc_q <= (redirect this cycle ? redirect_pc : redir_q); state<=RUN. stall does not block leaving DRAIN.
- HALT:
  - IF_instr=NOP_INSTR; pc_q held.
  - A redirect (an older branch resolved taken, so the HLT was speculative) sets pc_q<=redirect_pc and state<=RUN.
  - Only rst or redirect leaves HALT.
- Latency: with an always-hit memory and no stall or redirect, one instruction per cycle and the PC advances by 2 each cycle. Each miss cycle adds one bubble.

Test Plan:
- Reset release, imem_valid tied 1, rdata = 16'h1111, 16'h2222, ... → imem_addr 0, 2, 4 on consecutive cycles; IF_pc 2, 4, 6; fetch_bubble=0 throughout.
- imem_valid low 3 cycles at addr 16'h0004 → three cycles of IF_instr=16'h4000 with fetch_bubble=1, imem_addr held at 4; data at cycle 4 → IF_instr=rdata, then addr 16'h0006.
- redirect with redirect_pc=16'h0040 during a miss at addr 8 → DRAIN; addr held at 8 until imem_valid; returned data discarded as NOP; next imem_addr=16'h0040. Second redirect to 16'h0080 during DRAIN → 16'h0080 wins.
- stall=1 for 2 cycles at addr 16'h0010 with hits → addr held at 16'h0010; with redirect to 16'h0020 in the same cycle as stall → next addr 16'h0020.
- Fetch 16'hF000 at addr 16'h000C → delivered once, then halted=1, imem_req=0, NOP output; later redirect to 16'h0030 → halted=0, fetch resumes at 16'h0030.
- Assert rst low mid-miss (state WAIT, pc 16'h0022) → pc immediately 0, state RUN, IF_instr=16'h4000; wrap case: pc 16'hFFFE with a hit → next pc 16'h0000.
